// File: rtl/expr_feeder_if.sv
// Byte-source and calculator-core handshake bundle for expr_feeder.
// master = the driving environment, slave = the feeder itself.
interface expr_feeder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       aec_valid;
  logic       aec_ready;
  logic [7:0] aec_ascii;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output in_valid, in_data, aec_valid,
    input  in_ready, aec_ready, aec_ascii, err, err_code
  );

  modport slave (
    input  in_valid, in_data, aec_valid,
    output in_ready, aec_ready, aec_ascii, err, err_code
  );
endinterface

// File: rtl/expr_feeder.sv
// Framing stage: buffers an ASCII expression up to '=', drops malformed frames
// with an error code, and replays legal ones to the calculator core.
module expr_feeder #(
  parameter int DEPTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  expr_feeder_if.slave bus
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0]        PTR_ZERO  = PW'(0);
  localparam logic [PW-1:0]        PTR_ONE   = PW'(1);
  localparam logic [PW-1:0]        PTR_FULL  = PW'(DEPTH);
  localparam logic signed [PW-1:0] DEP_ZERO  = PW'(0);
  localparam logic signed [PW-1:0] DEP_ONE   = PW'(1);
  localparam logic [7:0]           CH_EQ     = 8'd61;
  localparam logic [7:0]           CH_LP     = 8'd40;
  localparam logic [7:0]           CH_RP     = 8'd41;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_DISCARD = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_STREAM  = 3'd3,
    ST_WAIT    = 3'd4
  } state_t;

  state_t                 state_r;
  logic [7:0]             buf_r [DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic signed [PW-1:0]   paren_r;
  logic [1:0]             code_r;
  logic                   in_ready_r;
  logic                   aec_ready_r;
  logic [7:0]             aec_ascii_r;
  logic                   err_r;
  logic [1:0]             err_code_r;
  logic                   xfer_s;

  function automatic logic is_legal(input logic [7:0] c);
    is_legal = ((c >= 8'd48) && (c <= 8'd57))  ||
               ((c >= 8'd97) && (c <= 8'd102)) ||
               ((c >= 8'd40) && (c <= 8'd43))  ||
               (c == 8'd45) || (c == 8'd61);
  endfunction

  assign xfer_s        = bus.in_valid && in_ready_r;
  assign bus.in_ready  = in_ready_r;
  assign bus.aec_ready = aec_ready_r;
  assign bus.aec_ascii = aec_ascii_r;
  assign bus.err       = err_r;
  assign bus.err_code  = err_code_r;

  // Frame FSM with buffer, pointers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_COLLECT;
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      paren_r     <= DEP_ZERO;
      code_r      <= 2'd0;
      in_ready_r  <= 1'b0;
      aec_ready_r <= 1'b0;
      aec_ascii_r <= CH_EQ;
      err_r       <= 1'b0;
      err_code_r  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) buf_r[i] <= 8'd0;
    end else begin
      err_r       <= 1'b0;
      aec_ready_r <= 1'b0;
      aec_ascii_r <= CH_EQ;
      case (state_r)
        ST_COLLECT: begin
          in_ready_r <= 1'b1;
          if (xfer_s) begin
            if (!is_legal(bus.in_data)) begin
              code_r  <= 2'd1;
              state_r <= ST_DISCARD;
            end else if (bus.in_data == CH_EQ) begin
              if ((wr_ptr_r == PTR_ZERO) || (paren_r != DEP_ZERO)) begin
                err_r      <= 1'b1;
                err_code_r <= 2'd3;
                wr_ptr_r   <= PTR_ZERO;
                rd_ptr_r   <= PTR_ZERO;
                paren_r    <= DEP_ZERO;
              end else begin
                in_ready_r <= 1'b0;
                state_r    <= ST_LAUNCH;
              end
            end else if (wr_ptr_r == PTR_FULL) begin
              code_r  <= 2'd2;
              state_r <= ST_DISCARD;
            end else if ((bus.in_data == CH_RP) && (paren_r == DEP_ZERO)) begin
              code_r  <= 2'd3;
              state_r <= ST_DISCARD;
            end else begin
              buf_r[wr_ptr_r[PW-2:0]] <= bus.in_data;
              wr_ptr_r <= wr_ptr_r + PTR_ONE;
              if (bus.in_data == CH_LP) begin
                paren_r <= paren_r + DEP_ONE;
              end else if (bus.in_data == CH_RP) begin
                paren_r <= paren_r - DEP_ONE;
              end else begin
                paren_r <= paren_r;
              end
            end
          end
        end
        ST_DISCARD: begin
          in_ready_r <= 1'b1;
          if (xfer_s && (bus.in_data == CH_EQ)) begin
            err_r      <= 1'b1;
            err_code_r <= code_r;
            wr_ptr_r   <= PTR_ZERO;
            paren_r    <= DEP_ZERO;
            state_r    <= ST_COLLECT;
          end
        end
        ST_LAUNCH: begin
          in_ready_r  <= 1'b0;
          aec_ready_r <= 1'b1;
          rd_ptr_r    <= PTR_ZERO;
          state_r     <= ST_STREAM;
        end
        ST_STREAM: begin
          in_ready_r <= 1'b0;
          // rd_ptr == wr_ptr is the '=' cycle; one step further hands over to WAIT.
          if (rd_ptr_r < wr_ptr_r) begin
            aec_ascii_r <= buf_r[rd_ptr_r[PW-2:0]];
            rd_ptr_r    <= rd_ptr_r + PTR_ONE;
          end else if (rd_ptr_r == wr_ptr_r) begin
            aec_ascii_r <= CH_EQ;
            rd_ptr_r    <= rd_ptr_r + PTR_ONE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          in_ready_r <= bus.aec_valid;
          if (bus.aec_valid) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            paren_r  <= DEP_ZERO;
            state_r  <= ST_COLLECT;
          end
        end
        default: begin
          in_ready_r <= 1'b0;
          wr_ptr_r   <= PTR_ZERO;
          rd_ptr_r   <= PTR_ZERO;
          paren_r    <= DEP_ZERO;
          state_r    <= ST_COLLECT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_expr_feeder.sv
// Scoreboard bench for expr_feeder: expected streams/errors are queued as
// frames are sent and compared cycle by cycle as the feeder responds.
module tb_expr_feeder;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    int         len;
  } exp_t;

  exp_t       fq[$];
  logic [7:0] cq[$];

  expr_feeder_if bus ();

  expr_feeder #(.DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_ok(input string s);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'd0; e.len = s.len() + 1;
    fq.push_back(e);
    for (int i = 0; i < s.len(); i++) cq.push_back(8'(s[i]));
    cq.push_back(8'd61);
  endtask

  task automatic expect_err(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.len = 0;
    fq.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout got in_ready=%b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
  endtask

  task automatic pulse_valid();
    bus.aec_valid = 1'b1;
    @(negedge clk);
    bus.aec_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
  endtask

  // Pops one frame expectation and follows the feeder's response to it.
  task automatic check_out(input bit rel);
    exp_t e;
    logic [7:0] want;
    if (fq.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
      return;
    end
    e = fq.pop_front();
    @(negedge clk);
    if (e.is_err) begin
      n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b want 1", bus.err); end
      n_checks++; if (bus.err_code !== e.code) begin n_fail++; $display("FAIL err_code got %0d want %0d", bus.err_code, e.code); end
      n_checks++; if (bus.aec_ready !== 1'b0) begin n_fail++; $display("FAIL err_no_start got %b want 0", bus.aec_ready); end
      @(negedge clk);
      n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle got %b want 0", bus.err); end
      n_checks++; if (bus.err_code !== e.code) begin n_fail++; $display("FAIL err_code_hold got %0d want %0d", bus.err_code, e.code); end
      n_checks++; if (bus.aec_ready !== 1'b0) begin n_fail++; $display("FAIL err_no_start2 got %b want 0", bus.aec_ready); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL err_in_ready got %b want 1", bus.in_ready); end
    end else begin
      n_checks++; if (bus.aec_ready !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL launch_early got ready=%b err=%b want 0 0", bus.aec_ready, bus.err); end
      @(negedge clk);
      n_checks++; if (bus.aec_ready !== 1'b1) begin n_fail++; $display("FAIL start_pulse got %b want 1", bus.aec_ready); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL backpressure got %b want 0", bus.in_ready); end
      for (int i = 0; i < e.len; i++) begin
        @(negedge clk);
        want = cq.pop_front();
        n_checks++; if (bus.aec_ascii !== want) begin n_fail++; $display("FAIL stream_char%0d got %0d want %0d", i, bus.aec_ascii, want); end
        n_checks++; if (bus.aec_ready !== 1'b0) begin n_fail++; $display("FAIL start_one_cycle got %b want 0", bus.aec_ready); end
      end
      repeat (2) begin
        @(negedge clk);
        n_checks++; if (bus.aec_ascii !== 8'd61 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL wait_idle got ascii=%0d in_ready=%b want 61 0", bus.aec_ascii, bus.in_ready); end
      end
      if (rel) pulse_valid();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.aec_valid = 1'b0;
    #12;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    n_checks++; if (bus.aec_ready !== 1'b0) begin n_fail++; $display("FAIL rst_aec_ready got %b want 0", bus.aec_ready); end
    n_checks++; if (bus.aec_ascii !== 8'd61) begin n_fail++; $display("FAIL rst_aec_ascii got %0d want 61", bus.aec_ascii); end
    n_checks++; if (bus.err !== 1'b0 || bus.err_code !== 2'd0) begin n_fail++; $display("FAIL rst_err got %b/%0d want 0/0", bus.err, bus.err_code); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    expect_ok("3+4*2");
    send_str("3+4*2=");
    check_out(1'b1);
  endtask

  task automatic test_back_to_back();
    expect_ok("(a-2)*3");
    send_str("(a-2)*3=");
    check_out(1'b0);
    expect_ok("f");
    fork
      send_str("f=");
      begin
        repeat (4) begin
          @(negedge clk);
          n_checks++; if (bus.in_ready !== 1'b0 || bus.aec_ready !== 1'b0) begin n_fail++; $display("FAIL hold_off got in_ready=%b aec_ready=%b want 0 0", bus.in_ready, bus.aec_ready); end
        end
        bus.aec_valid = 1'b1;
        @(negedge clk);
        bus.aec_valid = 1'b0;
      end
    join
    check_out(1'b1);
  endtask

  task automatic test_illegal();
    expect_err(2'd1);
    send_str("3&4=");
    check_out(1'b0);
    expect_ok("1+1");
    send_str("1+1=");
    check_out(1'b1);
  endtask

  task automatic test_overflow();
    expect_err(2'd2);
    send_str("12345678901234567=");
    check_out(1'b0);
    expect_ok("1+2+3+4+5+6+7+89");
    send_str("1+2+3+4+5+6+7+89=");
    check_out(1'b1);
  endtask

  task automatic test_parens();
    expect_err(2'd3);
    send_str("(1+2=");
    check_out(1'b0);
    expect_err(2'd3);
    send_str(")1=");
    check_out(1'b0);
    expect_err(2'd3);
    send_str("=");
    check_out(1'b0);
  endtask

  task automatic test_mid_reset();
    send_str("5*5=");
    repeat (3) @(negedge clk);
    n_checks++; if (bus.aec_ascii !== 8'd53) begin n_fail++; $display("FAIL pre_reset_char got %0d want 53", bus.aec_ascii); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.aec_ascii !== 8'd61 || bus.aec_ready !== 1'b0) begin n_fail++; $display("FAIL abort_outputs got ascii=%0d ready=%b want 61 0", bus.aec_ascii, bus.aec_ready); end
    n_checks++; if (bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_err got err=%b in_ready=%b want 0 0", bus.err, bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL after_abort got in_ready=%b err=%b want 1 0", bus.in_ready, bus.err); end
    expect_ok("2");
    send_str("2=");
    check_out(1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_overflow();
    test_parens();
    test_mid_reset();
    n_checks++; if (fq.size() != 0 || cq.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d/%0d want 0/0", fq.size(), cq.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
